// File: rtl/mem_arb_pkg.sv
// Shared command and state codes for the data-RAM arbiter (also used by the cpu).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } arb_state_t;

  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned MEM_RAM_AW = 8;

  function automatic logic is_req(input logic req, input logic [1:0] cmd);
    return req && (cmd != MNONE);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker; MEM_ARBITER_ROUND_ROBIN_EN selects round-robin,
// otherwise port 0 wins every tie.
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    valid = req0 | req1;
    grant = (req0 & req1) ? ~last : ~req0;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid = req0 | req1;
    grant = ~req0;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port data RAM with req/ack handshake.
// Tie policy is set by MEM_ARBITER_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned RAM_AW = MEM_RAM_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [1:0]        cmd0,
  input  logic [RAM_AW:0]   addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [1:0]        cmd1,
  input  logic [RAM_AW:0]   addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [RAM_AW-1:0] ram_raddr,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_t        state_q, state_d;
  mem_cmd_t          cmd_q;
  logic              sel_q, last_q;
  logic [RAM_AW:0]   addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q, rd_val;
  logic              act0, act1, grant, grant_valid, in_range, rd_done;

  assign act0 = is_req(req0, cmd0);
  assign act1 = is_req(req1, cmd1);

  mem_arb_pick u_pick (
    .req0  (act0),
    .req1  (act1),
    .last  (last_q),
    .grant (grant),
    .valid (grant_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs decode from state so an async reset drops ram_write at once.
  always_comb begin
    state_d   = state_q;
    ack0      = 1'b0;
    ack1      = 1'b0;
    ram_write = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      IDLE:   if (grant_valid) state_d = ACCESS;
      ACCESS: begin
        ram_write = (cmd_q == MWRITE) && in_range;
        state_d   = DONE;
      end
      DONE: begin
        ack0    = ~sel_q;
        ack1    = sel_q;
        rd_done = (cmd_q == MREAD);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      cmd_q    <= MNONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state_q == IDLE && grant_valid) begin
        sel_q   <= grant;
        cmd_q   <= mem_cmd_t'(grant ? cmd1 : cmd0);
        addr_q  <= grant ? addr1 : addr0;
        wdata_q <= grant ? wdata1 : wdata0;
      end
      if (state_q == DONE) begin
        last_q <= sel_q;
        if (rd_done && !sel_q) rdata0_q <= rd_val;
        if (rd_done &&  sel_q) rdata1_q <= rd_val;
      end
    end
  end

  assign in_range  = ~addr_q[RAM_AW];
  assign rd_val    = in_range ? ram_dout : '0;
  // Read data is forwarded combinationally during DONE, then held in the register.
  assign rdata0    = (rd_done && !sel_q) ? rd_val : rdata0_q;
  assign rdata1    = (rd_done &&  sel_q) ? rd_val : rdata1_q;
  assign ram_raddr = addr_q[RAM_AW-1:0];
  assign ram_waddr = addr_q[RAM_AW-1:0];
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus
// directed and randomized traffic on both ports.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, ack0, ack1, ram_write;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1, rdata0, rdata1, ram_wdata, ram_dout;
  logic [7:0]  ram_raddr, ram_waddr;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(16), .RAM_AW(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_dout(ram_dout)
  );

  // Environment RAM: registered read, write commits at the clock edge.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    ram_dout <= ram[ram_raddr];
    if (ram_write) ram[ram_waddr] = ram_wdata;
  end

  // Reference model: one transaction in flight, age 0 = RAM access cycle, 1 = ack cycle.
  logic [15:0] ref_mem [256];
  int          busy_age;
  int          m_port, m_last;
  logic [1:0]  m_cmd;
  logic [8:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata [2];

  // Masters.
  logic        p_req [2];
  logic [1:0]  p_cmd [2];
  logic [8:0]  p_addr [2];
  logic [15:0] p_wdata [2];
  bit          auto_gen, sticky;

  int          passes, total, cyc, wr_cnt;
  int          ack_cyc [2];
  int          ack_cnt [2];
  logic [15:0] got_rdata [2];
  logic [7:0]  last_waddr;
  int          ack_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit real_pending(input int p);
    return p_req[p] && (p_cmd[p] != MNONE);
  endfunction

  task automatic check_cycle();
    logic e_ack0, e_ack1, e_wr;
    e_ack0 = (busy_age == 1) && (m_port == 0);
    e_ack1 = (busy_age == 1) && (m_port == 1);
    e_wr   = (busy_age == 0) && (m_cmd == MWRITE) && !m_addr[8];
    if (busy_age == 1 && m_cmd == MREAD)
      m_rdata[m_port] = m_addr[8] ? 16'h0000 : ref_mem[m_addr[7:0]];
    chk("ack0", ack0, e_ack0);
    chk("ack1", ack1, e_ack1);
    chk("ram_write", ram_write, e_wr);
    chk("rdata0", rdata0, m_rdata[0]);
    chk("rdata1", rdata1, m_rdata[1]);
    if (busy_age == 0) begin
      chk("ram_raddr", ram_raddr, m_addr[7:0]);
      chk("ram_waddr", ram_waddr, m_addr[7:0]);
      chk("ram_wdata", ram_wdata, m_wdata);
    end
    if (ram_write === 1'b1) begin wr_cnt++; last_waddr = ram_waddr; end
    if (ack0 === 1'b1) begin ack_cnt[0]++; ack_cyc[0] = cyc; got_rdata[0] = rdata0; ack_log.push_back(0); end
    if (ack1 === 1'b1) begin ack_cnt[1]++; ack_cyc[1] = cyc; got_rdata[1] = rdata1; ack_log.push_back(1); end
  endtask

  task automatic gen(input int p);
    int r;
    r = int'($urandom_range(0, 5));
    case (r)
      0: begin p_req[p] = 1'b0; p_cmd[p] = 2'($urandom_range(0, 2)); end
      1: begin p_req[p] = 1'b1; p_cmd[p] = MNONE; end
      default: begin
        p_req[p]   = 1'b1;
        p_cmd[p]   = ($urandom_range(0, 1) == 0) ? MREAD : MWRITE;
        p_addr[p]  = ($urandom_range(0, 7) == 0) ? {1'b1, 8'($urandom)} : {5'b0, 4'($urandom_range(0, 15))};
        p_wdata[p] = 16'($urandom);
      end
    endcase
  endtask

  task automatic drive();
    logic a;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? ack0 : ack1;
      if (a && !sticky) p_req[p] = 1'b0;
      if (auto_gen && !real_pending(p)) gen(p);
    end
    req0 = p_req[0]; cmd0 = p_cmd[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
    req1 = p_req[1]; cmd1 = p_cmd[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
  endtask

  // What the coming clock edge does, given the inputs just driven.
  task automatic advance();
    bit r0, r1;
    int w;
    if (busy_age == 0) begin
      if (m_cmd == MWRITE && !m_addr[8]) ref_mem[m_addr[7:0]] = m_wdata;
      busy_age = 1;
    end else if (busy_age == 1) begin
      m_last   = m_port;
      busy_age = -1;
    end else begin
      r0 = req0 && (cmd0 != MNONE);
      r1 = req1 && (cmd1 != MNONE);
      if (r0 || r1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        w = (r0 && r1) ? ((m_last == 0) ? 1 : 0) : (r0 ? 0 : 1);
`else
        w = r0 ? 0 : 1;
`endif
        m_port   = w;
        m_cmd    = (w == 0) ? cmd0 : cmd1;
        m_addr   = (w == 0) ? addr0 : addr1;
        m_wdata  = (w == 0) ? wdata0 : wdata1;
        busy_age = 0;
      end
    end
  endtask

  task automatic step();
    cyc++;
    @(negedge clk);
    check_cycle();
    drive();
    advance();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((real_pending(0) || real_pending(1) || busy_age != -1) && n < budget) begin
      step();
      n++;
    end
    chk("drain_bound", (n < budget), 1'b1);
  endtask

  task automatic issue(input int p, input logic [1:0] c, input logic [8:0] a,
                       input logic [15:0] d, output int lat);
    int start;
    p_req[p] = 1'b1; p_cmd[p] = c; p_addr[p] = a; p_wdata[p] = d;
    start = cyc + 1;
    run_until_idle(20);
    lat = ack_cyc[p] - start;
  endtask

  task automatic model_reset();
    busy_age = -1; m_last = 1; m_port = 0; m_cmd = MNONE; m_addr = '0; m_wdata = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_cmd[p] = MNONE; p_addr[p] = '0; p_wdata[p] = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base_w, base_a, n;
    int exp_order [4];
    logic [15:0] v;

    passes = 0; total = 0; cyc = 0; wr_cnt = 0; last_waddr = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0; ack_cyc[0] = 0; ack_cyc[1] = 0;
    auto_gen = 0; sticky = 0;
    for (int i = 0; i < 256; i++) begin
      v = 16'(i * 257) ^ 16'h5a5a;
      ram[i] = v;
      ref_mem[i] = v;
    end
    model_reset();
    reset = 1'b0;
    req0 = 0; cmd0 = MNONE; addr0 = '0; wdata0 = '0;
    req1 = 0; cmd1 = MNONE; addr1 = '0; wdata1 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_rdata0", rdata0, 16'h0000);
    chk("rst_rdata1", rdata1, 16'h0000);
    chk("rst_ram_write", ram_write, 1'b0);
    chk("rst_ram_raddr", ram_raddr, 8'h00);
    chk("rst_ram_waddr", ram_waddr, 8'h00);
    chk("rst_ram_wdata", ram_wdata, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) step();
    chk("idle_no_write", wr_cnt, 0);

    // Port 0 write then read back.
    base_w = wr_cnt;
    issue(0, MWRITE, 9'h005, 16'hABCD, lat);
    chk("wr_pulses", wr_cnt - base_w, 1);
    chk("wr_waddr", last_waddr, 8'h05);
    chk("wr_latency", lat, 2);
    issue(0, MREAD, 9'h005, 16'h0000, lat);
    chk("rd_data_005", got_rdata[0], 16'hABCD);
    chk("rd_latency", lat, 2);

    // Port 1 out-of-range write and read.
    base_w = wr_cnt;
    base_a = ack_cnt[1];
    issue(1, MWRITE, 9'h105, 16'h1234, lat);
    chk("oor_no_write", wr_cnt - base_w, 0);
    chk("oor_acked", ack_cnt[1] - base_a, 1);
    issue(1, MREAD, 9'h105, 16'h0000, lat);
    chk("oor_read_zero", got_rdata[1], 16'h0000);
    issue(1, MREAD, 9'h005, 16'h0000, lat);
    chk("ram05_unchanged", got_rdata[1], 16'hABCD);

    // Both ports reading, requests held continuously.
    ack_log.delete();
    sticky = 1;
    p_req[0] = 1; p_cmd[0] = MREAD; p_addr[0] = 9'h001; p_wdata[0] = '0;
    p_req[1] = 1; p_cmd[1] = MREAD; p_addr[1] = 9'h002; p_wdata[1] = '0;
    n = 0;
    while (ack_log.size() < 4 && n < 40) begin step(); n++; end
    chk("tie_acks_seen", (ack_log.size() >= 4), 1'b1);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
    chk("tie_rdata1", got_rdata[1], 16'h5858);
`else
    exp_order = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++)
      if (i < ack_log.size()) chk($sformatf("tie_order%0d", i), ack_log[i], exp_order[i]);
    chk("tie_rdata0", got_rdata[0], 16'h5b5b);
    sticky = 0;
    run_until_idle(40);

    // Reset asserted during the ACCESS cycle of a write.
    p_req[0] = 1; p_cmd[0] = MWRITE; p_addr[0] = 9'h0AA; p_wdata[0] = 16'h7777;
    step();
    @(posedge clk);
    #1;
    chk("abort_write_hi", ram_write, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_write_drop", ram_write, 1'b0);
    chk("abort_no_ack0", ack0, 1'b0);
    model_reset();
    @(negedge clk);
    req0 = 0; cmd0 = MNONE;
    reset = 1'b1;
    repeat (4) step();
    chk("abort_ram_aa", ram[8'hAA], 16'hF0F0);
    issue(0, MREAD, 9'h0AA, 16'h0000, lat);
    chk("abort_then_read", got_rdata[0], 16'hF0F0);
    chk("abort_idle_latency", lat, 2);

    // MNONE with req held: ignored.
    base_w = wr_cnt;
    base_a = ack_cnt[0];
    p_req[0] = 1; p_cmd[0] = MNONE; p_addr[0] = 9'h007; p_wdata[0] = 16'h5555;
    repeat (10) step();
    chk("mnone_no_ack", ack_cnt[0] - base_a, 0);
    chk("mnone_no_write", wr_cnt - base_w, 0);
    p_req[0] = 0;

    // Randomized traffic on both ports.
    auto_gen = 1;
    repeat (2000) step();
    auto_gen = 0;
    for (int p = 0; p < 2; p++) if (!real_pending(p)) p_req[p] = 0;
    run_until_idle(40);
    chk("random_acks_seen", (ack_cnt[0] > 50 && ack_cnt[1] > 20), 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
